// File: rtl/sfx_pkg.sv
// Shared types and priority helpers for the sound-effect scheduler.
package sfx_pkg;

  typedef enum logic [3:0] {
    SFX_NONE    = 4'd0,
    SFX_EXPLODE = 4'd1,
    SFX_FIRE    = 4'd2,
    SFX_INVADER = 4'd3,
    SFX_UFO     = 4'd4
  } sfx_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2
  } sched_st_t;

  // Lower id wins; SFX_NONE never wins and loses to everything.
  function automatic logic sfx_higher(input sfx_id_t a, input sfx_id_t b);
    return (a != SFX_NONE) && ((b == SFX_NONE) || (a < b));
  endfunction

  function automatic sfx_id_t sfx_pick(input logic [4:1] v);
    if (v[1]) return SFX_EXPLODE;
    else if (v[2]) return SFX_FIRE;
    else if (v[3]) return SFX_INVADER;
    else if (v[4]) return SFX_UFO;
    else return SFX_NONE;
  endfunction

endpackage

// File: rtl/sfx_pending_slot.sv
// One queued sound request with an age counter that drops it once it goes stale.
module sfx_pending_slot #(
  parameter int TIMEOUT = 2_000_000
) (
  input  logic MCLK,
  input  logic reset,
  input  logic flush,
  input  logic set,
  input  logic refresh,
  input  logic consume,
  output logic pend
);

  localparam int AW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(TIMEOUT - 1);

  logic [AW-1:0] age;

  // The bit is still visible during the cycle it expires, so a grant on that edge wins.
  always_ff @(posedge MCLK) begin
    if (reset || flush) begin
      pend <= 1'b0;
      age  <= '0;
    end else if (consume) begin
      pend <= 1'b0;
      age  <= '0;
    end else if (set || refresh) begin
      age <= '0;
      if (set) pend <= 1'b1;
    end else if (pend) begin
      if (age >= LAST) begin
        pend <= 1'b0;
        age  <= '0;
      end else begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Arbitrates game sound requests by fixed priority and drives the track player's
// select and active-low restart strobe.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int PEND_TIMEOUT = 2_000_000
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       onOff,
  input  logic       req_explode,
  input  logic       req_fire,
  input  logic       req_invader,
  input  logic       ufo_alive,
  input  logic       ufo_hit,
  input  logic       theme_ended,
  output logic [3:0] select,
  output logic       new_trackN,
  output logic       playing
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

  sched_st_t     st, st_n;
  sfx_id_t       cur, cur_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:1]    pulse, pend, set, consume, refresh;
  logic [4:1]    req_v;
  sfx_id_t       grant, hp;

  assign pulse   = {req_invader, req_fire, req_explode};
  assign req_v   = {ufo_alive & ~ufo_hit, pend | pulse};
  assign grant   = sfx_pick(req_v);
  assign hp      = sfx_pick({1'b0, pulse});
  assign refresh = pulse & pend & {3{onOff}};
  assign select  = 4'(cur);

  for (genvar g = 1; g <= 3; g++) begin : g_slot
    sfx_pending_slot #(.TIMEOUT(PEND_TIMEOUT)) u_slot (
      .MCLK    (MCLK),
      .reset   (reset),
      .flush   (~onOff),
      .set     (set[g]),
      .refresh (refresh[g]),
      .consume (consume[g]),
      .pend    (pend[g])
    );
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      st         <= ST_IDLE;
      cur        <= SFX_NONE;
      cnt        <= '0;
      new_trackN <= 1'b1;
      playing    <= 1'b0;
    end else begin
      st         <= st_n;
      cur        <= cur_n;
      cnt        <= cnt_n;
      new_trackN <= (st_n != ST_START);
      playing    <= (st_n != ST_IDLE);
    end
  end

  always_comb begin
    st_n    = st;
    cur_n   = cur;
    cnt_n   = cnt;
    set     = '0;
    consume = '0;
    if (!onOff) begin
      st_n  = ST_IDLE;
      cur_n = SFX_NONE;
      cnt_n = '0;
    end else if (st == ST_IDLE) begin
      if (grant != SFX_NONE) begin
        st_n  = ST_START;
        cur_n = grant;
        cnt_n = '0;
        for (int i = 1; i <= 3; i++) begin
          if (i == int'(grant)) consume[i] = 1'b1;
          else set[i] = pulse[i];
        end
      end
    end else if (sfx_higher(hp, cur)) begin
      // Preemption: the current track is abandoned, lower pulses queue up.
      st_n  = ST_START;
      cur_n = hp;
      cnt_n = '0;
      for (int i = 1; i <= 3; i++) begin
        if (i == int'(hp)) consume[i] = 1'b1;
        else set[i] = pulse[i];
      end
    end else begin
      for (int i = 1; i <= 3; i++)
        set[i] = pulse[i] && !(i == 1 && cur == SFX_EXPLODE) && !(i == 2 && cur == SFX_FIRE);
      if (req_fire && cur == SFX_FIRE) begin
        st_n  = ST_START;
        cnt_n = '0;
      end else if (cur == SFX_UFO && (ufo_hit || !ufo_alive)) begin
        st_n  = ST_IDLE;
        cur_n = SFX_NONE;
      end else if (st == ST_START) begin
        if (cnt == CNT_LAST) st_n = ST_PLAY;
        else cnt_n = cnt + 1'b1;
      end else if (theme_ended) begin
        st_n  = ST_IDLE;
        cur_n = SFX_NONE;
      end
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with RST_CYCLES=4 and PEND_TIMEOUT=100.
module tb_sfx_scheduler;

  localparam int RST = 4;
  localparam int TMO = 100;

  logic       MCLK = 1'b0;
  logic       reset, onOff;
  logic       req_explode, req_fire, req_invader;
  logic       ufo_alive, ufo_hit, theme_ended;
  logic [3:0] select;
  logic       new_trackN, playing;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  sfx_scheduler #(.RST_CYCLES(RST), .PEND_TIMEOUT(TMO)) dut (
    .MCLK        (MCLK),
    .reset       (reset),
    .onOff       (onOff),
    .req_explode (req_explode),
    .req_fire    (req_fire),
    .req_invader (req_invader),
    .ufo_alive   (ufo_alive),
    .ufo_hit     (ufo_hit),
    .theme_ended (theme_ended),
    .select      (select),
    .new_trackN  (new_trackN),
    .playing     (playing)
  );

  // clock / reset block
  always #5 MCLK = ~MCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic pulse(input logic e, input logic f, input logic i);
    req_explode = e; req_fire = f; req_invader = i;
    step(1);
    req_explode = 0; req_fire = 0; req_invader = 0;
  endtask

  // Called right after the edge that grants a track: full low window then PLAY.
  task automatic start_window(input logic [3:0] id, input string tag);
    check({tag, "_sel"}, select, id);
    check({tag, "_ntN0"}, new_trackN, 0);
    check({tag, "_play"}, playing, 1);
    for (int k = 1; k < RST; k++) begin
      step(1);
      check({tag, "_ntN_low"}, new_trackN, 0);
    end
    step(1);
    check({tag, "_ntN_high"}, new_trackN, 1);
    check({tag, "_sel_play"}, select, id);
    check({tag, "_playing"}, playing, 1);
  endtask

  task automatic end_track(input string tag);
    theme_ended = 1;
    step(1);
    theme_ended = 0;
    check({tag, "_end_sel"}, select, 0);
    check({tag, "_end_play"}, playing, 0);
  endtask

  task automatic expect_next(input string tag);
    logic [3:0] id;
    id = exp_q.pop_front();
    start_window(id, tag);
  endtask

  initial begin
    reset = 1; onOff = 1;
    req_explode = 0; req_fire = 0; req_invader = 0;
    ufo_alive = 0; ufo_hit = 0; theme_ended = 0;
    step(2);
    check("rst_sel", select, 0);
    check("rst_ntN", new_trackN, 1);
    check("rst_play", playing, 0);
    reset = 0;
    step(2);
    check("idle_sel", select, 0);

    // single fire track, then end
    pulse(0, 1, 0);
    start_window(4'd2, "fire");
    step(3);
    end_track("fire");
    step(1);
    check("fire_no_replay", select, 0);

    // simultaneous explode + invader: explode first, invader queued
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    pulse(1, 0, 1);
    expect_next("q_expl");
    end_track("q_expl");
    step(1);
    expect_next("q_inv");
    end_track("q_inv");
    step(2);
    check("q_empty", select, 0);

    // explode preempts a playing invader; invader is not replayed
    pulse(0, 0, 1);
    start_window(4'd3, "pre_inv");
    step(2);
    pulse(1, 0, 0);
    start_window(4'd1, "pre_expl");
    // explode retrigger while explode current is dropped
    pulse(1, 0, 0);
    check("expl_drop_ntN", new_trackN, 1);
    check("expl_drop_sel", select, 1);
    end_track("pre_expl");
    step(2);
    check("pre_no_inv", select, 0);
    check("pre_no_play", playing, 0);

    // fire retrigger restarts the window
    pulse(0, 1, 0);
    start_window(4'd2, "rtg1");
    step(2);
    pulse(0, 1, 0);
    start_window(4'd2, "rtg2");
    end_track("rtg");
    step(1);

    // UFO loop, fire preemption, UFO resumption, ufo_hit stop
    ufo_alive = 1;
    step(1);
    start_window(4'd4, "ufo1");
    end_track("ufo1");
    step(1);
    start_window(4'd4, "ufo2");
    pulse(0, 1, 0);
    start_window(4'd2, "ufo_fire");
    end_track("ufo_fire");
    step(1);
    start_window(4'd4, "ufo3");
    step(3);
    ufo_hit = 1;
    step(1);
    ufo_hit = 0; ufo_alive = 0;
    check("ufo_hit_sel", select, 0);
    check("ufo_hit_ntN", new_trackN, 1);
    check("ufo_hit_play", playing, 0);
    step(3);
    check("ufo_no_restart", select, 0);

    // pending expiry boundary: end at S+99 still grants the invader
    pulse(1, 0, 0);
    start_window(4'd1, "tmoA");
    pulse(0, 0, 1);                 // edge S
    step(TMO - 2);                  // through edge S+98
    end_track("tmoA");              // theme_ended sampled at S+99
    step(1);
    start_window(4'd3, "tmoA_inv");
    end_track("tmoA_inv");
    step(1);

    // ending at S+100 finds the request already dropped
    pulse(1, 0, 0);
    start_window(4'd1, "tmoB");
    pulse(0, 0, 1);
    step(TMO - 1);
    end_track("tmoB");
    step(2);
    check("tmoB_dropped", select, 0);
    check("tmoB_idle", playing, 0);

    // mute mid-START flushes pending
    pulse(1, 0, 1);
    check("mute_start", new_trackN, 0);
    step(1);
    onOff = 0;
    step(1);
    check("mute_ntN", new_trackN, 1);
    check("mute_sel", select, 0);
    check("mute_play", playing, 0);
    pulse(0, 1, 0);
    check("mute_ignored", select, 0);
    onOff = 1;
    step(3);
    check("mute_flushed", select, 0);

    // reset mid-PLAY with a queued invader
    pulse(0, 1, 0);
    start_window(4'd2, "rst_play");
    pulse(0, 0, 1);
    reset = 1;
    step(1);
    reset = 0;
    check("rstp_sel", select, 0);
    check("rstp_ntN", new_trackN, 1);
    check("rstp_play", playing, 0);
    step(3);
    check("rstp_flushed", select, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
